acc_classifier: RTL and testbench

Multi-cycle inference accelerator on the responder side of the CPU's ACC instruction port. While an ACC instruction executes, the CPU drives two 16-bit operand words and a start level. This block unpacks the words into eight 4-bit features and scores them against ten linear class weight vectors, one class per cycle. It returns the argmax class index on `predict` with `acc_done`, which the CPU writes back to its destination register.

---
 rtl/acc_classifier.sv | 195 +++++++++++++++++++
 tb/tb_acc_classifier.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_classifier.sv
// acc_classifier: ACC-instruction inference responder.
// Unpacks two 16-bit operand words into eight unsigned 4-bit features and
// scores them against NUM_CLASS linear weight vectors, one class per clock.
// The index of the highest score (ties go to the lower index) is returned on
// predict together with acc_done.
//
// Optional feature: define ACC_BIAS_EN to add a signed 8-bit per-class bias
// to every score. Without it the bias ports are ignored.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start_i             level, high while the CPU executes an ACC instruction
//   rm_i, rn_i          operand words (features f0..f3, f4..f7 by nibble)
//   w_we/w_addr/w_data  weight write, w_addr = class*8 + feature
//   b_we/b_addr/b_data  bias write (ACC_BIAS_EN only)
//   acc_done            result valid (high in DONE)
//   predict             winning class index, held until the next result
//   busy_o              inference in progress
module acc_classifier #(
    parameter int unsigned NUM_CLASS = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [15:0] rm_i,
    input  logic [15:0] rn_i,
    input  logic        w_we,
    input  logic [6:0]  w_addr,
    input  logic [3:0]  w_data,
    input  logic        b_we,
    input  logic [3:0]  b_addr,
    input  logic [7:0]  b_data,
    output logic        acc_done,
    output logic [3:0]  predict,
    output logic        busy_o
);

    localparam int unsigned NUM_FEAT = 8;
    localparam int unsigned FEAT_W   = 4;
    localparam int unsigned WGT_W    = 4;
    localparam int unsigned PROD_W   = 9;
    localparam int unsigned ACC_W    = 12;
    localparam int unsigned IDX_W    = 4;
    localparam int unsigned ADDR_W   = 7;
    localparam int unsigned NUM_WGT  = NUM_CLASS * NUM_FEAT;

    localparam logic signed [ACC_W-1:0] SCORE_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic        [WGT_W-1:0]  weights [NUM_WGT];
    logic        [FEAT_W-1:0] feat_q  [NUM_FEAT];
    logic        [IDX_W-1:0]  cls_q;
    logic signed [ACC_W-1:0]  best_score;
    logic        [IDX_W-1:0]  best_idx;

    logic                     last_cls;
    logic                     wr_open;
    logic                     better;
    logic        [31:0]       operands;
    logic signed [ACC_W-1:0]  score;
    logic signed [PROD_W-1:0] fx;
    logic signed [PROD_W-1:0] wx;
    logic signed [PROD_W-1:0] prod;
    logic signed [WGT_W-1:0]  wsel;

    assign operands = {rn_i, rm_i};
    assign wr_open  = (state_q != BUSY);
    assign better   = (score > best_score);

    // Weight storage; writes are locked out while an inference is running.
    always_ff @(posedge clk or negedge rst_n) begin : weight_store
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_WGT; i++) begin
                weights[i] <= '0;
            end
        end else if (wr_open && w_we && (w_addr < ADDR_W'(NUM_WGT))) begin
            weights[w_addr] <= w_data;
        end
    end

`ifdef ACC_BIAS_EN
    logic        [7:0] bias [NUM_CLASS];
    logic signed [7:0] bsel;

    // Per-class bias storage, same write lockout as the weights.
    always_ff @(posedge clk or negedge rst_n) begin : bias_store
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_CLASS; i++) begin
                bias[i] <= '0;
            end
        end else if (wr_open && b_we && (b_addr < IDX_W'(NUM_CLASS))) begin
            bias[b_addr] <= b_data;
        end
    end

    assign bsel = bias[cls_q];
`else
    logic unused_bias;
    assign unused_bias = ^{b_we, b_addr, b_data};
`endif

    // 8-wide MAC for the class currently selected by cls_q.
    always_comb begin : class_score
        score = '0;
        fx    = '0;
        wx    = '0;
        prod  = '0;
        wsel  = '0;
        for (int unsigned k = 0; k < NUM_FEAT; k++) begin
            wsel  = weights[{cls_q, 3'(k)}];
            fx    = PROD_W'(feat_q[k]);
            wx    = PROD_W'(wsel);
            prod  = fx * wx;
            score = score + ACC_W'(prod);
        end
`ifdef ACC_BIAS_EN
        score = score + ACC_W'(bsel);
`endif
    end

    // Next-state logic.
    always_comb begin : next_state
        state_d  = state_q;
        last_cls = (cls_q == IDX_W'(NUM_CLASS - 1));
        unique case (state_q)
            IDLE:    if (start_i) state_d = BUSY;
            BUSY:    if (last_cls) state_d = DONE;
            DONE:    if (!start_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register and state-derived status outputs.
    always_ff @(posedge clk or negedge rst_n) begin : state_reg
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_done <= 1'b0;
            busy_o   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_done <= (state_d == DONE);
            busy_o   <= (state_d == BUSY);
        end
    end

    // Operand capture, running argmax and result register.
    always_ff @(posedge clk or negedge rst_n) begin : datapath
        if (!rst_n) begin
            for (int unsigned k = 0; k < NUM_FEAT; k++) begin
                feat_q[k] <= '0;
            end
            cls_q      <= '0;
            best_score <= SCORE_MIN;
            best_idx   <= '0;
            predict    <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        for (int unsigned k = 0; k < NUM_FEAT; k++) begin
                            feat_q[k] <= operands[k*FEAT_W +: FEAT_W];
                        end
                        cls_q      <= '0;
                        best_score <= SCORE_MIN;
                        best_idx   <= '0;
                    end
                end
                BUSY: begin
                    cls_q <= cls_q + IDX_W'(1);
                    if (better) begin
                        best_score <= score;
                        best_idx   <= cls_q;
                    end
                    // Last class: fold its comparison straight into the result.
                    if (last_cls) begin
                        predict <= better ? cls_q : best_idx;
                    end
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_acc_classifier.sv
// tb_acc_classifier: randomized scoreboard bench for acc_classifier.
// Stimulus pushes the reference-model prediction into a queue; a monitor
// process pops and compares on every rising acc_done.
module tb_acc_classifier;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic [15:0] rm_i;
    logic [15:0] rn_i;
    logic        w_we;
    logic [6:0]  w_addr;
    logic [3:0]  w_data;
    logic        b_we;
    logic [3:0]  b_addr;
    logic [7:0]  b_data;
    logic        acc_done;
    logic [3:0]  predict;
    logic        busy_o;

    int n_checks;
    int n_fail;
    int exp_q[$];
    int wm[80];
    int bm[10];

    acc_classifier dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start_i),
        .rm_i     (rm_i),
        .rn_i     (rn_i),
        .w_we     (w_we),
        .w_addr   (w_addr),
        .w_data   (w_data),
        .b_we     (b_we),
        .b_addr   (b_addr),
        .b_data   (b_data),
        .acc_done (acc_done),
        .predict  (predict),
        .busy_o   (busy_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: plain dot products plus optional bias, strict argmax.
    function automatic int model_predict(input int rm, input int rn);
        int f[8];
        int best;
        int bi;
        int s;
        for (int k = 0; k < 4; k++) begin
            f[k]     = (rm >> (4 * k)) & 15;
            f[k + 4] = (rn >> (4 * k)) & 15;
        end
        best = -100000;
        bi   = 0;
        for (int c = 0; c < 10; c++) begin
            s = 0;
`ifdef ACC_BIAS_EN
            s = bm[c];
`endif
            for (int k = 0; k < 8; k++) s += f[k] * wm[c * 8 + k];
            if (s > best) begin
                best = s;
                bi   = c;
            end
        end
        return bi;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 80; i++) wm[i] = 0;
        for (int i = 0; i < 10; i++) bm[i] = 0;
    endtask

    task automatic run_monitor();
        logic prev;
        int   e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (acc_done && !prev) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: acc_done rose with no pending inference (t=%0t)", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("predict", int'(predict), e);
                end
            end
            prev = acc_done;
        end
    endtask

    // All drive tasks start and end at a negedge.
    task automatic write_w(input int addr, input int val);
        w_we   = 1'b1;
        w_addr = 7'(addr);
        w_data = 4'(val);
        if (addr < 80) wm[addr] = val;
        @(posedge clk);
        @(negedge clk);
        w_we = 1'b0;
    endtask

    task automatic write_b(input int addr, input int val);
        b_we   = 1'b1;
        b_addr = 4'(addr);
        b_data = 8'(val);
`ifdef ACC_BIAS_EN
        if (addr < 10) bm[addr] = val;
`endif
        @(posedge clk);
        @(negedge clk);
        b_we = 1'b0;
    endtask

    task automatic fill_weights(input int cls_val[10]);
        for (int a = 0; a < 80; a++) write_w(a, cls_val[a / 8]);
    endtask

    // mode 0: plain; 1: toggle start + weight write during BUSY;
    // 2: hold start 20 cycles in DONE; 3: weight write in the capture cycle.
    task automatic run_inf(input logic [15:0] rm, input logic [15:0] rn, input int mode);
        int cnt;
        rm_i    = rm;
        rn_i    = rn;
        start_i = 1'b1;
        if (mode == 3) begin
            w_we   = 1'b1;
            w_addr = 7'd49;
            w_data = 4'd7;
            wm[49] = 7;
        end
        exp_q.push_back(model_predict(int'(rm), int'(rn)));
        @(posedge clk);
        cnt = 0;
        forever begin
            @(negedge clk);
            w_we = 1'b0;
            if (cnt == 0) check("busy_after_capture", int'(busy_o), 1);
            if (acc_done || cnt >= 30) break;
            if (mode == 1 && cnt >= 1 && cnt <= 4) begin
                start_i = cnt[0];
                w_we    = 1'b1;
                w_addr  = 7'd32;
                w_data  = 4'd7;
            end else begin
                start_i = 1'b1;
            end
            @(posedge clk);
            cnt++;
        end
        check("done_latency_edges", cnt, 10);
        check("busy_at_done", int'(busy_o), 0);
        if (mode == 2) begin
            for (int i = 0; i < 20; i++) begin
                @(posedge clk);
                @(negedge clk);
                check("done_held", int'(acc_done), 1);
            end
        end
        start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("done_fall", int'(acc_done), 0);
    endtask

    task automatic reset_mid_busy();
        rm_i    = 16'h1234;
        rn_i    = 16'h5678;
        start_i = 1'b1;
        @(posedge clk);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("busy_before_reset", int'(busy_o), 1);
        rst_n   = 1'b0;
        start_i = 1'b0;
        #1;
        check("rst_acc_done", int'(acc_done), 0);
        check("rst_predict", int'(predict), 0);
        check("rst_busy", int'(busy_o), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int cv[10];
        int waits;
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        start_i  = 1'b0;
        rm_i     = '0;
        rn_i     = '0;
        w_we     = 1'b0;
        w_addr   = '0;
        w_data   = '0;
        b_we     = 1'b0;
        b_addr   = '0;
        b_data   = '0;
        model_reset();
        fork
            run_monitor();
        join_none
        repeat (3) @(negedge clk);
        check("reset_acc_done", int'(acc_done), 0);
        check("reset_predict", int'(predict), 0);
        check("reset_busy", int'(busy_o), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // All-zero weights: every score 0, lowest index wins.
        run_inf(16'hFFFF, 16'hFFFF, 0);

        // Class 3 all +1.
        for (int k = 0; k < 8; k++) write_w(24 + k, 1);
        run_inf(16'h1111, 16'h1111, 0);

        // Classes 2 and 5 identical: tie resolves to 2.
        for (int k = 0; k < 8; k++) write_w(24 + k, 0);
        for (int k = 0; k < 8; k++) begin
            write_w(16 + k, 2);
            write_w(40 + k, 2);
        end
        run_inf(16'h2222, 16'h2222, 0);

        // All -1 except class 9.
        for (int c = 0; c < 10; c++) cv[c] = (c == 9) ? 0 : -1;
        fill_weights(cv);
        run_inf(16'h3333, 16'h3333, 0);

        // Held start, then BUSY-time toggling and a dropped write.
        run_inf(16'h3333, 16'h3333, 2);
        run_inf(16'h3333, 16'h3333, 1);
        run_inf(16'h3333, 16'h3333, 0);

        // Out-of-range weight addresses are dropped.
        for (int a = 80; a < 128; a += 7) write_w(a, 7);
        run_inf(16'h3333, 16'h3333, 0);

        // Write in the capture cycle is used by that inference.
        run_inf(16'h3333, 16'h3333, 3);

        // Abort mid-BUSY, then a fresh inference from cleared weights.
        reset_mid_busy();
        write_w(40, 1);
        run_inf(16'h0001, 16'h0000, 0);

        // Bias on class 7 (no effect without ACC_BIAS_EN).
        write_w(40, 0);
        write_b(7, 1);
        write_b(12, 100);
        run_inf(16'hFFFF, 16'hFFFF, 0);

        // Randomized weights, biases and operands.
        for (int it = 0; it < 25; it++) begin
            for (int j = 0; j < 12; j++) begin
                write_w(int'($urandom_range(0, 99)), int'($urandom_range(0, 15)) - 8);
            end
            write_b(int'($urandom_range(0, 12)), int'($urandom_range(0, 255)) - 128);
            run_inf(16'($urandom), 16'($urandom), 0);
        end

        waits = 0;
        while (exp_q.size() != 0 && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
